// File: rtl/rip_axi_slave_mem.sv
// AXI4 responder backed by a word-addressed on-chip memory; independent write and read FSMs.
// Optional RIP_AXI_SLAVE_RANGE_CHECK_EN: bursts running past MEM_DEPTH answer SLVERR.
module rip_axi_slave_mem #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 1024
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [ID_WIDTH-1:0]     s_axi_awid_i,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr_i,
    input  logic [7:0]              s_axi_awlen_i,
    input  logic [2:0]              s_axi_awsize_i,
    input  logic [1:0]              s_axi_awburst_i,
    input  logic                    s_axi_awlock_i,
    input  logic [3:0]              s_axi_awcache_i,
    input  logic [2:0]              s_axi_awprot_i,
    input  logic [3:0]              s_axi_awqos_i,
    input  logic [3:0]              s_axi_awregion_i,
    input  logic                    s_axi_awvalid_i,
    output logic                    s_axi_awready_o,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb_i,
    input  logic                    s_axi_wlast_i,
    input  logic                    s_axi_wvalid_i,
    output logic                    s_axi_wready_o,
    output logic [ID_WIDTH-1:0]     s_axi_bid_o,
    output logic [1:0]              s_axi_bresp_o,
    output logic                    s_axi_bvalid_o,
    input  logic                    s_axi_bready_i,
    input  logic [ID_WIDTH-1:0]     s_axi_arid_i,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr_i,
    input  logic [7:0]              s_axi_arlen_i,
    input  logic [2:0]              s_axi_arsize_i,
    input  logic [1:0]              s_axi_arburst_i,
    input  logic                    s_axi_arlock_i,
    input  logic [3:0]              s_axi_arcache_i,
    input  logic [2:0]              s_axi_arprot_i,
    input  logic [3:0]              s_axi_arqos_i,
    input  logic [3:0]              s_axi_arregion_i,
    input  logic                    s_axi_arvalid_i,
    output logic                    s_axi_arready_o,
    output logic [ID_WIDTH-1:0]     s_axi_rid_o,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata_o,
    output logic [1:0]              s_axi_rresp_o,
    output logic                    s_axi_rlast_o,
    output logic                    s_axi_rvalid_o,
    input  logic                    s_axi_rready_i
);
    localparam int unsigned StrbW = DATA_WIDTH / 8;
    localparam int unsigned OffW  = $clog2(StrbW);
    localparam int unsigned IdxW  = $clog2(MEM_DEPTH);
    localparam logic [1:0]  RespOkay   = 2'b00;
    localparam logic [1:0]  RespSlverr = 2'b10;

    typedef enum logic [1:0] {WIdle, WData, WResp} wstate_e;
    typedef enum logic [0:0] {RIdle, RData} rstate_e;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    wstate_e             wstate_q, wstate_d;
    logic [IdxW-1:0]     widx_q, widx_d;
    logic [7:0]          wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic                werr_q, werr_d;
    logic                awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [ID_WIDTH-1:0] bid_q, bid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic                mem_we;

    rstate_e               rstate_q, rstate_d;
    logic [IdxW-1:0]       ridx_q, ridx_d, ridx_nxt;
    logic [7:0]            rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic                  rerr_q, rerr_d;
    logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [IdxW-1:0] aw_idx, ar_idx;
    logic            aw_oor, ar_oor;

    assign aw_idx = s_axi_awaddr_i[OffW +: IdxW];
    assign ar_idx = s_axi_araddr_i[OffW +: IdxW];

`ifdef RIP_AXI_SLAVE_RANGE_CHECK_EN
    logic [IdxW+8:0] aw_end, ar_end;
    // Any carry above the index bits means the burst ends past the last word.
    assign aw_end = {9'b0, aw_idx} + {{(IdxW + 1){1'b0}}, s_axi_awlen_i};
    assign ar_end = {9'b0, ar_idx} + {{(IdxW + 1){1'b0}}, s_axi_arlen_i};
    assign aw_oor = |aw_end[IdxW+8:IdxW];
    assign ar_oor = |ar_end[IdxW+8:IdxW];
`else
    assign aw_oor = 1'b0;
    assign ar_oor = 1'b0;
`endif

    logic unused_axi;
    assign unused_axi = ^{s_axi_awaddr_i, s_axi_awsize_i, s_axi_awburst_i, s_axi_awlock_i,
                          s_axi_awcache_i, s_axi_awprot_i, s_axi_awqos_i, s_axi_awregion_i,
                          s_axi_araddr_i, s_axi_arsize_i, s_axi_arburst_i, s_axi_arlock_i,
                          s_axi_arcache_i, s_axi_arprot_i, s_axi_arqos_i, s_axi_arregion_i};

    always_comb begin
        wstate_d = wstate_q;
        widx_d   = widx_q;
        wlen_d   = wlen_q;
        wcnt_d   = wcnt_q;
        werr_d   = werr_q;
        bid_d    = bid_q;
        bresp_d  = bresp_q;
        mem_we   = 1'b0;
        unique case (wstate_q)
            WIdle: begin
                if (s_axi_awvalid_i && awready_q) begin
                    bid_d    = s_axi_awid_i;
                    widx_d   = aw_idx;
                    wlen_d   = s_axi_awlen_i;
                    wcnt_d   = 8'd0;
                    werr_d   = aw_oor;
                    bresp_d  = aw_oor ? RespSlverr : RespOkay;
                    wstate_d = WData;
                end
            end
            WData: begin
                if (s_axi_wvalid_i && wready_q) begin
                    mem_we = !werr_q;
                    widx_d = widx_q + 1'b1;
                    wcnt_d = wcnt_q + 8'd1;
                    if (s_axi_wlast_i || (wcnt_q == wlen_q)) begin
                        wstate_d = WResp;
                    end
                end
            end
            WResp: begin
                if (s_axi_bready_i && bvalid_q) begin
                    wstate_d = WIdle;
                end
            end
            default: wstate_d = WIdle;
        endcase
        awready_d = (wstate_d == WIdle);
        wready_d  = (wstate_d == WData);
        bvalid_d  = (wstate_d == WResp);
    end

    assign ridx_nxt = ridx_q + 1'b1;

    always_comb begin
        rstate_d = rstate_q;
        ridx_d   = ridx_q;
        rlen_d   = rlen_q;
        rcnt_d   = rcnt_q;
        rerr_d   = rerr_q;
        rid_d    = rid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        rlast_d  = rlast_q;
        unique case (rstate_q)
            RIdle: begin
                if (s_axi_arvalid_i && arready_q) begin
                    rid_d    = s_axi_arid_i;
                    ridx_d   = ar_idx;
                    rlen_d   = s_axi_arlen_i;
                    rcnt_d   = 8'd0;
                    rerr_d   = ar_oor;
                    rresp_d  = ar_oor ? RespSlverr : RespOkay;
                    rdata_d  = ar_oor ? '0 : mem_q[ar_idx];
                    rlast_d  = (s_axi_arlen_i == 8'd0);
                    rstate_d = RData;
                end
            end
            RData: begin
                if (s_axi_rready_i && rvalid_q) begin
                    if (rlast_q) begin
                        rstate_d = RIdle;
                    end else begin
                        // Next beat is fetched at this handshake, so RDATA holds during stalls.
                        ridx_d  = ridx_nxt;
                        rcnt_d  = rcnt_q + 8'd1;
                        rdata_d = rerr_q ? '0 : mem_q[ridx_nxt];
                        rlast_d = ((rcnt_q + 8'd1) == rlen_q);
                    end
                end
            end
            default: rstate_d = RIdle;
        endcase
        arready_d = (rstate_d == RIdle);
        rvalid_d  = (rstate_d == RData);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wstate_q  <= WIdle;
            widx_q    <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            werr_q    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
            rstate_q  <= RIdle;
            ridx_q    <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rerr_q    <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= '0;
            rdata_q   <= '0;
        end else begin
            wstate_q  <= wstate_d;
            widx_q    <= widx_d;
            wlen_q    <= wlen_d;
            wcnt_q    <= wcnt_d;
            werr_q    <= werr_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            rstate_q  <= rstate_d;
            ridx_q    <= ridx_d;
            rlen_q    <= rlen_d;
            rcnt_q    <= rcnt_d;
            rerr_q    <= rerr_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < StrbW; b++) begin
                if (s_axi_wstrb_i[b]) begin
                    mem_q[widx_q][b*8 +: 8] <= s_axi_wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign s_axi_awready_o = awready_q;
    assign s_axi_wready_o  = wready_q;
    assign s_axi_bvalid_o  = bvalid_q;
    assign s_axi_bid_o     = bid_q;
    assign s_axi_bresp_o   = bresp_q;
    assign s_axi_arready_o = arready_q;
    assign s_axi_rvalid_o  = rvalid_q;
    assign s_axi_rlast_o   = rlast_q;
    assign s_axi_rid_o     = rid_q;
    assign s_axi_rresp_o   = rresp_q;
    assign s_axi_rdata_o   = rdata_q;

endmodule
